spi_arb: RTL and testbench
==========================

Name: spi_arb

Overview:
- Two-requester arbiter for the single SPI master in the digital core.
- Requester A is the host command path: pot/trigger config and EEPROM reads. Requester B is the calibration sequencer, which reads EEPROM cal bytes and writes offset/gain pots.
- The block latches the winning request, drives ss/SPI_data/wrt_SPI, waits for SPI_done, and returns a done pulse plus the captured EEP_data byte to the winner.
- Arbitration is round-robin. A timeout guards against a missing SPI_done.

Parameters:
- TO_W, 16, width of the timeout counter. Timeout fires after 2^TO_W-1 cycles in WAIT.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- reqA  in  1  requester A request; level, held until doneA
- ssA  in  3  requester A slave select; stable while reqA high
- dataA  in  16  requester A SPI word; stable while reqA high
- reqB  in  1  requester B request
- ssB  in  3  requester B slave select
- dataB  in  16  requester B SPI word
- gntA  out  1  A owns the SPI master
- gntB  out  1  B owns the SPI master
- doneA  out  1  one-cycle pulse: A transaction finished
- doneB  out  1  one-cycle pulse: B transaction finished
- err  out  1  valid with done pulse; 1 = timeout, 0 = normal
- rdata  out  8  EEP_data captured at SPI_done; 8'h00 on timeout
- busy  out  1  state != IDLE
- ss  out  3  to SPI master / slave decode
- SPI_data  out  16  to SPI master
- wrt_SPI  out  1  one-cycle start pulse to SPI master
- SPI_done  in  1  SPI master transaction-complete pulse
- EEP_data  in  8  SPI master received byte

Behaviour:
- All outputs are registered.
- Reset values: gntA=gntB=0, doneA=doneB=0, err=0, rdata=8'h00, ss=3'b000, SPI_data=16'h0000, wrt_SPI=0, busy=0, state=IDLE, timeout count=0, last_gnt=B.
- IDLE state:
  - Samples reqA/reqB each cycle.
  - Only one request high: that requester wins.
  - Both high: the requester not equal to last_gnt wins. After reset, A wins the first tie.
  - On the next edge: gntX=1, ss<=ssX, SPI_data<=dataX, wrt_SPI=1 for exactly one cycle, count cleared, last_gnt<=X, state->WAIT.
  - Latency: request sampled at edge N gives wrt_SPI high during cycle N+1.
- WAIT state:
  - The count increments each cycle.
  - On SPI_done=1: doneX=1 for one cycle, rdata<=EEP_data, err<=0, state->HOLD.
  - Else if count reaches 2^TO_W-1: doneX=1, err<=1, rdata<=8'h00, state->HOLD.
  - SPI_done and the terminal count in the same cycle: SPI_done wins (err=0).
- HOLD state: exactly one cycle. gntX cleared, doneX back to 0, state->IDLE. This gives a registered requester time to drop its request.
- Requester contract:
  - Deassert req no later than the edge following doneX.
  - req dropped during WAIT is ignored; the transaction completes and doneX still pulses.
  - req is never sampled outside IDLE.
- Output hold rules:
  - ss and SPI_data hold their last values after a transaction; they are not cleared.
  - err and rdata hold until the next done pulse.
- SPI_done received in IDLE or HOLD is ignored: no done pulse, rdata unchanged.
- Exclusivity: gntA and gntB are never both high, and doneA and doneB are never both high.
- Minimum turnaround between back-to-back transactions is 4 cycles of overhead around SPI time: wrt_SPI, WAIT, HOLD, IDLE sample.
- Asynchronous reset mid-transaction: all state and outputs return to reset values immediately. No done pulse is issued for the aborted transaction. The SPI master is reset by the same rst_n.

Test Plan:
- A-only request: reqA=1, ssA=3'b100, dataA=16'h0305. Required: one wrt_SPI pulse, ss=100, SPI_data=16'h0305. Drive SPI_done with EEP_data=8'hA5 after 40 cycles. Required: doneA one-cycle pulse, rdata=8'hA5, err=0, gntA low the cycle after doneA.
- Simultaneous reqA/reqB from reset, both held through three transactions. Required grant order A, B, A; never both granted; doneA/doneB each exactly one cycle.
- Fairness: A re-requests immediately after each doneA while B stays pending. Required: B granted before A's second transaction.
- Timeout with TO_W=4: no SPI_done. Required: doneX with err=1 and rdata=8'h00 exactly 15 cycles after entering WAIT. A later normal transaction returns err=0.
- Spurious SPI_done in IDLE (EEP_data=8'h3C). Required: no done pulse, rdata unchanged. SPI_done coincident with the terminal count gives err=0.
- rst_n asserted during WAIT. Required: all outputs immediately at reset values, no done pulse. After release with reqB held, B is granted and wrt_SPI pulses once.

Source files
------------

// File: rtl/spi_arb.sv
// Purpose: two-requester round-robin arbiter in front of the single SPI master, with a WAIT timeout.
// Latency: a request sampled at edge N gives wrt_SPI in cycle N+1; the done pulse follows SPI_done by one edge.
// Backpressure: requests are level-held until done; they are only sampled in IDLE, never while WAIT or HOLD.
module spi_arb #(
    parameter int TO_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reqA,
    input  logic [2:0]  ssA,
    input  logic [15:0] dataA,
    input  logic        reqB,
    input  logic [2:0]  ssB,
    input  logic [15:0] dataB,
    output logic        gntA,
    output logic        gntB,
    output logic        doneA,
    output logic        doneB,
    output logic        err,
    output logic [7:0]  rdata,
    output logic        busy,
    output logic [2:0]  ss,
    output logic [15:0] SPI_data,
    output logic        wrt_SPI,
    input  logic        SPI_done,
    input  logic [7:0]  EEP_data
);

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    localparam logic [TO_W-1:0] CNT_ONE = {{(TO_W-1){1'b0}}, 1'b1};
    localparam logic [TO_W-1:0] CNT_MAX = {TO_W{1'b1}};

    state_t           state, state_nxt;
    logic             last_b, last_b_nxt;   // 1 = B held the last grant
    logic [TO_W-1:0]  cnt, cnt_nxt;
    logic             gnt_a_nxt, gnt_b_nxt, done_a_nxt, done_b_nxt;
    logic             err_nxt, busy_nxt, wrt_nxt;
    logic [7:0]       rdata_nxt;
    logic [2:0]       ss_nxt;
    logic [15:0]      data_nxt;

    // State register and registered outputs; reset aborts any transaction silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last_b   <= 1'b1;
            cnt      <= '0;
            gntA     <= 1'b0;
            gntB     <= 1'b0;
            doneA    <= 1'b0;
            doneB    <= 1'b0;
            err      <= 1'b0;
            rdata    <= 8'h00;
            busy     <= 1'b0;
            ss       <= 3'b000;
            SPI_data <= 16'h0000;
            wrt_SPI  <= 1'b0;
        end else begin
            state    <= state_nxt;
            last_b   <= last_b_nxt;
            cnt      <= cnt_nxt;
            gntA     <= gnt_a_nxt;
            gntB     <= gnt_b_nxt;
            doneA    <= done_a_nxt;
            doneB    <= done_b_nxt;
            err      <= err_nxt;
            rdata    <= rdata_nxt;
            busy     <= busy_nxt;
            ss       <= ss_nxt;
            SPI_data <= data_nxt;
            wrt_SPI  <= wrt_nxt;
        end
    end

    // Next-state and next-output logic; pulses default low, everything else holds.
    always_comb begin
        state_nxt  = state;
        last_b_nxt = last_b;
        cnt_nxt    = cnt;
        gnt_a_nxt  = gntA;
        gnt_b_nxt  = gntB;
        done_a_nxt = 1'b0;
        done_b_nxt = 1'b0;
        err_nxt    = err;
        rdata_nxt  = rdata;
        ss_nxt     = ss;
        data_nxt   = SPI_data;
        wrt_nxt    = 1'b0;
        case (state)
            IDLE: begin
                // On a tie the requester that did not win last time goes first.
                if (reqA && (!reqB || last_b)) begin
                    gnt_a_nxt  = 1'b1;
                    ss_nxt     = ssA;
                    data_nxt   = dataA;
                    wrt_nxt    = 1'b1;
                    cnt_nxt    = '0;
                    last_b_nxt = 1'b0;
                    state_nxt  = WAIT;
                end else if (reqB) begin
                    gnt_b_nxt  = 1'b1;
                    ss_nxt     = ssB;
                    data_nxt   = dataB;
                    wrt_nxt    = 1'b1;
                    cnt_nxt    = '0;
                    last_b_nxt = 1'b1;
                    state_nxt  = WAIT;
                end
            end
            WAIT: begin
                cnt_nxt = cnt + CNT_ONE;
                // A real completion beats a coincident terminal count.
                if (SPI_done) begin
                    done_a_nxt = gntA;
                    done_b_nxt = gntB;
                    rdata_nxt  = EEP_data;
                    err_nxt    = 1'b0;
                    state_nxt  = HOLD;
                end else if (cnt_nxt == CNT_MAX) begin
                    done_a_nxt = gntA;
                    done_b_nxt = gntB;
                    rdata_nxt  = 8'h00;
                    err_nxt    = 1'b1;
                    state_nxt  = HOLD;
                end
            end
            HOLD: begin
                // One idle cycle lets a registered requester drop its request.
                gnt_a_nxt = 1'b0;
                gnt_b_nxt = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_spi_arb.sv
module tb_spi_arb;

    logic        clk, rst_n;
    logic        reqA, reqB, SPI_done;
    logic [2:0]  ssA, ssB;
    logic [15:0] dataA, dataB;
    logic [7:0]  EEP_data;
    logic        gntA, gntB, doneA, doneB, err, busy, wrt_SPI;
    logic [7:0]  rdata;
    logic [2:0]  ss;
    logic [15:0] SPI_data;

    // second instance with a short timeout
    logic        reqA_t, reqB_t, SPI_done_t;
    logic [2:0]  ssA_t, ssB_t;
    logic [15:0] dataA_t, dataB_t;
    logic [7:0]  EEP_data_t;
    logic        gntA_t, gntB_t, doneA_t, doneB_t, err_t, busy_t, wrt_SPI_t;
    logic [7:0]  rdata_t;
    logic [2:0]  ss_t;
    logic [15:0] SPI_data_t;

    spi_arb u_dut (
        .clk(clk), .rst_n(rst_n), .reqA(reqA), .ssA(ssA), .dataA(dataA),
        .reqB(reqB), .ssB(ssB), .dataB(dataB), .gntA(gntA), .gntB(gntB),
        .doneA(doneA), .doneB(doneB), .err(err), .rdata(rdata), .busy(busy),
        .ss(ss), .SPI_data(SPI_data), .wrt_SPI(wrt_SPI), .SPI_done(SPI_done),
        .EEP_data(EEP_data)
    );

    spi_arb #(.TO_W(4)) u_to (
        .clk(clk), .rst_n(rst_n), .reqA(reqA_t), .ssA(ssA_t), .dataA(dataA_t),
        .reqB(reqB_t), .ssB(ssB_t), .dataB(dataB_t), .gntA(gntA_t), .gntB(gntB_t),
        .doneA(doneA_t), .doneB(doneB_t), .err(err_t), .rdata(rdata_t), .busy(busy_t),
        .ss(ss_t), .SPI_data(SPI_data_t), .wrt_SPI(wrt_SPI_t), .SPI_done(SPI_done_t),
        .EEP_data(EEP_data_t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic who; logic [2:0] ss; logic [15:0] data; } gexp_t;
    typedef struct { logic who; logic err; logic [7:0] rdata; } rexp_t;
    gexp_t gq[$];
    rexp_t rq[$];

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: grants popped on wrt_SPI, results popped on done pulses.
    logic prev_wrt, prev_done, prev_da, prev_db;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_wrt  <= 1'b0;
            prev_done <= 1'b0;
            prev_da   <= 1'b0;
            prev_db   <= 1'b0;
        end else begin
            chk("excl_gnt", 32'(gntA & gntB), 32'd0);
            chk("excl_done", 32'(doneA & doneB), 32'd0);
            if (wrt_SPI) begin
                gexp_t g;
                chk("wrt_width", 32'(prev_wrt), 32'd0);
                if (gq.size() == 0) chk("unexpected_wrt", 32'd1, 32'd0);
                else begin
                    g = gq.pop_front();
                    chk("gnt_who", 32'({gntA, gntB}), g.who ? 32'd1 : 32'd2);
                    chk("ss", 32'(ss), 32'(g.ss));
                    chk("spi_data", 32'(SPI_data), 32'(g.data));
                end
            end
            if (doneA | doneB) begin
                rexp_t r;
                chk("done_width", 32'(prev_done), 32'd0);
                if (rq.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
                else begin
                    r = rq.pop_front();
                    chk("done_who", 32'({doneA, doneB}), r.who ? 32'd1 : 32'd2);
                    chk("err", 32'(err), 32'(r.err));
                    chk("rdata", 32'(rdata), 32'(r.rdata));
                end
            end
            if (prev_da) chk("gntA_drop", 32'(gntA), 32'd0);
            if (prev_db) chk("gntB_drop", 32'(gntB), 32'd0);
            prev_wrt  <= wrt_SPI;
            prev_done <= doneA | doneB;
            prev_da   <= doneA;
            prev_db   <= doneB;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_wrt(input string tag);
        int k = 0;
        while (!wrt_SPI && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!wrt_SPI) chk(tag, 32'd0, 32'd1);
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (!(doneA | doneB) && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!(doneA | doneB)) chk(tag, 32'd0, 32'd1);
    endtask

    task automatic resp(input int dly, input logic [7:0] d, input logic who);
        rq.push_back('{who, 1'b0, d});
        cyc(dly);
        EEP_data = d;
        SPI_done = 1'b1;
        @(negedge clk);
        SPI_done = 1'b0;
    endtask

    // One transaction on the short-timeout instance; done_at < 0 means no SPI_done.
    task automatic to_run(input int done_at, input logic [7:0] d, output int n);
        int k = 0;
        reqA_t = 1'b1;
        @(negedge clk);
        while (!wrt_SPI_t && k < 10) begin
            @(negedge clk);
            k++;
        end
        if (!wrt_SPI_t) chk("to_wrt", 32'd0, 32'd1);
        reqA_t = 1'b0;   // dropped during WAIT: must be ignored
        n = 0;
        while (!doneA_t && n < 40) begin
            if (n == done_at) begin
                SPI_done_t = 1'b1;
                EEP_data_t = d;
            end
            @(negedge clk);
            SPI_done_t = 1'b0;
            n++;
        end
        if (!doneA_t) chk("to_done_seen", 32'd0, 32'd1);
        @(negedge clk);
        chk("to_done_width", 32'(doneA_t), 32'd0);
        chk("to_gnt_drop", 32'(gntA_t), 32'd0);
        cyc(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b0; reqA = 1'b0; reqB = 1'b0; SPI_done = 1'b0;
        ssA = '0; ssB = '0; dataA = '0; dataB = '0; EEP_data = '0;
        reqA_t = 1'b0; reqB_t = 1'b0; SPI_done_t = 1'b0;
        ssA_t = 3'd7; ssB_t = '0; dataA_t = 16'h7777; dataB_t = '0; EEP_data_t = '0;
        cyc(2);
        chk("reset_outs", 32'({gntA, gntB, doneA, doneB, err, rdata, ss, busy, wrt_SPI}), 32'd0);
        chk("reset_spi_data", 32'(SPI_data), 32'd0);
        rst_n = 1'b1;
        cyc(2);

        // A-only request, SPI_done after 40 cycles
        ssA = 3'b100; dataA = 16'h0305; reqA = 1'b1;
        gq.push_back('{1'b0, 3'b100, 16'h0305});
        @(negedge clk);
        chk("a_latency_wrt", 32'(wrt_SPI), 32'd1);
        chk("a_busy", 32'(busy), 32'd1);
        resp(40, 8'hA5, 1'b0);
        wait_done("a_done");
        reqA = 1'b0;
        @(negedge clk);
        chk("a_idle_busy", 32'(busy), 32'd0);
        cyc(2);

        // Tie from reset: A, B, A with both held
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        ssA = 3'd1; dataA = 16'h1111; ssB = 3'd2; dataB = 16'h2222;
        reqA = 1'b1; reqB = 1'b1;
        gq.push_back('{1'b0, 3'd1, 16'h1111});
        gq.push_back('{1'b1, 3'd2, 16'h2222});
        gq.push_back('{1'b0, 3'd1, 16'h1111});
        for (int i = 0; i < 3; i++) begin
            wait_wrt("tie_wrt");
            resp(3, 8'h10 + 8'(i), (i == 1));
            wait_done("tie_done");
        end
        reqA = 1'b0; reqB = 1'b0;
        cyc(3);

        // Fairness: A re-requests right after doneA while B is pending
        ssA = 3'd3; dataA = 16'h3333; reqA = 1'b1;
        gq.push_back('{1'b0, 3'd3, 16'h3333});
        wait_wrt("fair_wrt0");
        ssB = 3'd5; dataB = 16'h5555; reqB = 1'b1;
        gq.push_back('{1'b1, 3'd5, 16'h5555});
        gq.push_back('{1'b0, 3'd3, 16'h3333});
        resp(6, 8'h31, 1'b0);
        wait_done("fair_done0");
        reqA = 1'b0;
        @(negedge clk);
        reqA = 1'b1;
        wait_wrt("fair_wrt1");
        resp(4, 8'h52, 1'b1);
        wait_done("fair_done1");
        reqB = 1'b0;
        wait_wrt("fair_wrt2");
        resp(4, 8'h33, 1'b0);
        wait_done("fair_done2");
        reqA = 1'b0;
        cyc(3);
        chk("ss_hold", 32'(ss), 32'd3);
        chk("spi_data_hold", 32'(SPI_data), 32'h3333);
        chk("rdata_hold", 32'(rdata), 32'h33);
        chk("err_hold", 32'(err), 32'd0);

        // Spurious SPI_done in IDLE
        EEP_data = 8'h3C; SPI_done = 1'b1;
        @(negedge clk);
        SPI_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("spur_no_done", 32'(doneA | doneB), 32'd0);
            @(negedge clk);
        end
        chk("spur_rdata", 32'(rdata), 32'h33);

        // Reset during WAIT, then B granted after release
        ssB = 3'd6; dataB = 16'h6666; reqB = 1'b1;
        gq.push_back('{1'b1, 3'd6, 16'h6666});
        wait_wrt("rst_wrt0");
        cyc(5);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_outs", 32'({gntA, gntB, doneA, doneB, err, rdata, ss, busy, wrt_SPI}), 32'd0);
        chk("rst_spi_data", 32'(SPI_data), 32'd0);
        @(negedge clk);
        chk("rst_no_done", 32'(doneA | doneB), 32'd0);
        gq.push_back('{1'b1, 3'd6, 16'h6666});
        rst_n = 1'b1;
        wait_wrt("rst_wrt1");
        resp(5, 8'h66, 1'b1);
        wait_done("rst_done");
        reqB = 1'b0;
        cyc(3);

        // Short-timeout instance: normal, timeout, coincident, normal
        to_run(3, 8'h5A, n);
        chk("to_norm_n", 32'(n), 32'd4);
        chk("to_norm_err", 32'(err_t), 32'd0);
        chk("to_norm_rdata", 32'(rdata_t), 32'h5A);
        to_run(-1, 8'h00, n);
        chk("to_cycles", 32'(n), 32'd15);
        chk("to_err", 32'(err_t), 32'd1);
        chk("to_rdata", 32'(rdata_t), 32'h00);
        to_run(14, 8'hC3, n);
        chk("coinc_cycles", 32'(n), 32'd15);
        chk("coinc_err", 32'(err_t), 32'd0);
        chk("coinc_rdata", 32'(rdata_t), 32'hC3);
        to_run(2, 8'h77, n);
        chk("after_to_err", 32'(err_t), 32'd0);
        chk("after_to_rdata", 32'(rdata_t), 32'h77);

        chk("gq_empty", 32'(gq.size()), 32'd0);
        chk("rq_empty", 32'(rq.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
